mmio_mapper: RTL and testbench
==============================

Name: mmio_mapper

Overview:
Parametrised MMIO address decoder/multiplexer. It sits between the CPU data port and NSLV memory-mapped slaves (boot ROM, RAM, UART, timer, …).
It replaces fixed nibble decoding with a per-slave base/mask table and adds a per-transaction timeout and bus-error reporting. At most one transaction is in flight at a time; latency is fixed for zero-wait slaves.

Parameters:
NSLV, 8, number of slave ports (1..16)
AW, 32, address width
DW, 32, data width
BASE, {NSLV{AW'h0}}, packed slave base addresses; slave i occupies BASE[i*AW +: AW]
MASK, {NSLV{AW'h0}}, packed compare masks; slave i matches when (a & MASK_i) == (BASE_i & MASK_i)
TIMEOUT, 255, maximum WAIT cycles before a bus error (1..65535)
ERR_DATA, 32'hDEADBEEF, read data returned on error (truncated to DW)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
a  in  AW  master address
d  in  DW  master write data
we  in  1  master write request pulse
rd  in  1  master read request pulse
spo  out  DW  read data, valid while ready=1 after a completion
ready  out  1  mapper idle and accepting requests
err  out  1  last transaction faulted; valid with spo
s_a  out  NSLV*AW  per-slave address: latched address, full width
s_d  out  NSLV*DW  per-slave write data: latched data
s_we  out  NSLV  one-cycle write strobe to the selected slave
s_rd  out  NSLV  one-cycle read strobe to the selected slave
s_spo  in  NSLV*DW  slave read data
s_ready  in  NSLV  slave ready level; tie to 1 for zero-wait slaves

Behaviour:
- Reset values: state IDLE; spo=0; err=0; all s_we/s_rd=0; timeout counter=0. ready evaluates to 1 when we=rd=0.
- ready = (state==IDLE) & !(we|rd). This is combinational and matches the existing master contract.
- States: IDLE, DECODE, ISSUE, GUARD, WAIT.
- IDLE: on we|rd, latch a/d into a_r/d_r and go to DECODE.
  - we and rd together are treated as a write.
- DECODE: evaluate all NSLV matches on a_r; the lowest index wins. Register sel and hit.
  - No hit: go to IDLE with err=1 and spo=ERR_DATA. No strobe is issued.
- ISSUE: s_we[sel]=we_r and s_rd[sel]=rd_r for exactly this cycle; all other strobes stay 0. Go to GUARD.
- GUARD: s_ready is ignored; this gives the slave one cycle to drop ready. Clear the counter and go to WAIT.
- WAIT: if s_ready[sel]=1, capture spo<=s_spo[sel] (reads and writes alike), set err=0 and go to IDLE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no ready, set spo=ERR_DATA, err=1 and go to IDLE.
- Latency for a zero-wait slave: request sampled at edge E0; spo/err updated and state back in IDLE at E4. ready therefore returns high in the cycle after E4.
- Requests arriving while state!=IDLE are ignored; the master must wait for ready.
- spo/err hold their values until the next completion.
- s_a/s_d are broadcast to all slaves from a_r/d_r combinationally. Slaves do any local address slicing themselves.
- rst mid-transaction returns to IDLE the next edge, with no strobe that cycle. A slave already strobed completes on its own and its ready is ignored.
- The counter width is clog2(TIMEOUT+1); it never wraps, because it clears in GUARD.

Optional Feature:
MMIO_MAPPER_ERRLOG_EN
- Defined: adds output irq (1) and input irq_clr (1).
  - On any error completion: a 1-entry log stores the faulting address and the kind (0 = unmapped, 1 = timeout); irq is set to 1.
  - irq_clr=1 clears irq the next edge. A new error in the same cycle as irq_clr wins and irq stays 1.
  - Log outputs: elog_a (AW) and elog_kind (1).
  - rst clears irq, elog_a and elog_kind.
- Not defined: these ports and the registers are absent; err is the only fault indication.

Decomposition:
- Package mmio_pkg holds:
  - state encoding localparams;
  - the ERR_DATA default;
  - error-kind constants;
  - a clog2 function;
  - the standard SoC address map constants (BOOTM 0xF0000000/mask 0xF0000000, DISTM 0x10000000, GPIO 0x92000000/0xFF000000, UART 0x93000000, …).
- One sub-module, mmio_addr_match: a combinational priority match over NSLV base/mask pairs that outputs sel and hit.

Test Plan:
- Read slave 3 (BASE 0x93000000, MASK 0xFF000000, s_ready=1, s_spo=0x12345678) at a=0x93000004 -> s_rd[3] is one cycle at ISSUE; spo=0x12345678, err=0, ready high 5 cycles after request.
- Write d=0xA5A5A5A5 to a slave holding ready low for 6 WAIT cycles -> s_we pulses once with s_d=0xA5A5A5A5; completion after ready rises; no other strobe toggles.
- Read a=0x50000000 (unmapped) -> no strobe, err=1, spo=0xDEADBEEF; with ERRLOG: irq=1, elog_kind=0.
- Slave never ready, TIMEOUT=8 -> err=1, spo=0xDEADBEEF exactly 8 WAIT cycles after GUARD; next request to a good slave gives err=0.
- Overlapping masks on slaves 1 and 2 both matching -> only slave 1 is strobed.
- rst asserted in WAIT -> next cycle state IDLE, all strobes 0, ready=1; we and rd asserted together -> write strobe only.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO mapper: FSM state encoding, error kinds,
// error read data, a clog2 helper and the standard SoC address map.
package mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_GUARD  = 3'd3,
        ST_WAIT   = 3'd4
    } state_t;

    localparam logic [31:0] MMIO_ERR_DATA = 32'hDEAD_BEEF;

    localparam logic ERR_KIND_UNMAPPED = 1'b0;
    localparam logic ERR_KIND_TIMEOUT  = 1'b1;

    localparam logic [31:0] MAP_BOOTM_BASE = 32'hF000_0000;
    localparam logic [31:0] MAP_BOOTM_MASK = 32'hF000_0000;
    localparam logic [31:0] MAP_DISTM_BASE = 32'h1000_0000;
    localparam logic [31:0] MAP_DISTM_MASK = 32'hF000_0000;
    localparam logic [31:0] MAP_GPIO_BASE  = 32'h9200_0000;
    localparam logic [31:0] MAP_GPIO_MASK  = 32'hFF00_0000;
    localparam logic [31:0] MAP_UART_BASE  = 32'h9300_0000;
    localparam logic [31:0] MAP_UART_MASK  = 32'hFF00_0000;

    // Smallest r with 2**r >= value; bounded so the shift never reaches the sign bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational base/mask matcher over NSLV slaves; the lowest matching index wins.
module mmio_addr_match #(
    parameter int              NSLV = 8,
    parameter int              AW   = 32,
    parameter int              SW   = 3,
    parameter logic [NSLV*AW-1:0] BASE = '0,
    parameter logic [NSLV*AW-1:0] MASK = '0
) (
    input  logic [AW-1:0] a,
    output logic [SW-1:0] sel,
    output logic          hit
);

    logic [NSLV-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_match
            localparam logic [AW-1:0] BASE_I = BASE[gi*AW +: AW];
            localparam logic [AW-1:0] MASK_I = MASK[gi*AW +: AW];
            assign match[gi] = ((a & MASK_I) == (BASE_I & MASK_I));
        end
    endgenerate

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel = SW'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_mapper.sv
// MMIO decoder/multiplexer with per-slave base/mask table, per-transaction timeout
// and bus-error reporting. Optional error log + irq when MMIO_MAPPER_ERRLOG_EN is defined.
module mmio_mapper
    import mmio_pkg::*;
#(
    parameter int                 NSLV     = 8,
    parameter int                 AW       = 32,
    parameter int                 DW       = 32,
    parameter logic [NSLV*AW-1:0] BASE     = '0,
    parameter logic [NSLV*AW-1:0] MASK     = '0,
    parameter int                 TIMEOUT  = 255,
    parameter logic [31:0]        ERR_DATA = MMIO_ERR_DATA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      a,
    input  logic [DW-1:0]      d,
    input  logic               we,
    input  logic               rd,
    output logic [DW-1:0]      spo,
    output logic               ready,
    output logic               err,
`ifdef MMIO_MAPPER_ERRLOG_EN
    output logic               irq,
    input  logic               irq_clr,
    output logic [AW-1:0]      elog_a,
    output logic               elog_kind,
`endif
    output logic [NSLV*AW-1:0] s_a,
    output logic [NSLV*DW-1:0] s_d,
    output logic [NSLV-1:0]    s_we,
    output logic [NSLV-1:0]    s_rd,
    input  logic [NSLV*DW-1:0] s_spo,
    input  logic [NSLV-1:0]    s_ready
);

    localparam int SW = (NSLV > 1) ? clog2(NSLV) : 1;
    localparam int CW = clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] ERR_W = DW'(ERR_DATA);

    state_t          state_reg, state_next;
    logic [AW-1:0]   a_reg;
    logic [DW-1:0]   d_reg;
    logic            we_reg, rd_reg;
    logic [SW-1:0]   sel_reg;
    logic            hit_reg;
    logic [CW-1:0]   cnt_reg;
    logic [DW-1:0]   spo_reg;
    logic            err_reg;

    logic [SW-1:0]   match_sel;
    logic            match_hit;
    logic            req;
    logic            slave_ready;
    logic [DW-1:0]   slave_spo;
    logic            timeout_hit;

    mmio_addr_match #(
        .NSLV (NSLV),
        .AW   (AW),
        .SW   (SW),
        .BASE (BASE),
        .MASK (MASK)
    ) u_match (
        .a   (a_reg),
        .sel (match_sel),
        .hit (match_hit)
    );

    assign req         = we | rd;
    assign ready       = (state_reg == ST_IDLE) & ~req;
    assign spo         = spo_reg;
    assign err         = err_reg;
    assign slave_ready = s_ready[sel_reg];
    assign slave_spo   = s_spo[sel_reg*DW +: DW];
    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_bcast
            assign s_a[gi*AW +: AW] = a_reg;
            assign s_d[gi*DW +: DW] = d_reg;
        end
    endgenerate

    // Strobes are masked during reset so an aborted ISSUE never reaches a slave.
    always_comb begin
        s_we = '0;
        s_rd = '0;
        if ((state_reg == ST_ISSUE) && hit_reg && !rst) begin
            s_we[sel_reg] = we_reg;
            s_rd[sel_reg] = rd_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (req) state_next = ST_DECODE;
            ST_DECODE: state_next = match_hit ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  state_next = ST_GUARD;
            ST_GUARD:  state_next = ST_WAIT;
            ST_WAIT:   if (slave_ready || timeout_hit) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            d_reg   <= '0;
            we_reg  <= 1'b0;
            rd_reg  <= 1'b0;
            sel_reg <= '0;
            hit_reg <= 1'b0;
            cnt_reg <= '0;
            spo_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        a_reg  <= a;
                        d_reg  <= d;
                        we_reg <= we;
                        rd_reg <= rd & ~we;
                    end
                end
                ST_DECODE: begin
                    sel_reg <= match_sel;
                    hit_reg <= match_hit;
                    if (!match_hit) begin
                        spo_reg <= ERR_W;
                        err_reg <= 1'b1;
                    end
                end
                ST_GUARD: cnt_reg <= '0;
                ST_WAIT: begin
                    if (slave_ready) begin
                        spo_reg <= slave_spo;
                        err_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        spo_reg <= ERR_W;
                        err_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MMIO_MAPPER_ERRLOG_EN
    logic          err_event;
    logic          err_kind;
    logic          irq_reg;
    logic [AW-1:0] elog_a_reg;
    logic          elog_kind_reg;

    assign err_event = ((state_reg == ST_DECODE) && !match_hit) ||
                       ((state_reg == ST_WAIT) && !slave_ready && timeout_hit);
    assign err_kind  = (state_reg == ST_WAIT) ? ERR_KIND_TIMEOUT : ERR_KIND_UNMAPPED;

    // A fresh error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_reg       <= 1'b0;
            elog_a_reg    <= '0;
            elog_kind_reg <= 1'b0;
        end else if (err_event) begin
            irq_reg       <= 1'b1;
            elog_a_reg    <= a_reg;
            elog_kind_reg <= err_kind;
        end else if (irq_clr) begin
            irq_reg <= 1'b0;
        end
    end

    assign irq       = irq_reg;
    assign elog_a    = elog_a_reg;
    assign elog_kind = elog_kind_reg;
`endif

endmodule

// File: tb/tb_mmio_mapper.sv
// Table-driven self-checking bench for mmio_mapper: four slaves with per-slave
// latency models, plus hand-written reset-abort and post-reset sequences.
module tb_mmio_mapper;

    localparam int NSLV = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic              clk;
    logic              rst;
    logic [AW-1:0]     a_i;
    logic [DW-1:0]     d_i;
    logic              we_i, rd_i;
    logic [DW-1:0]     spo;
    logic              ready, err;
    logic [NSLV*AW-1:0] s_a;
    logic [NSLV*DW-1:0] s_d;
    logic [NSLV-1:0]   s_we, s_rd;
    logic [NSLV*DW-1:0] s_spo;
    logic [NSLV-1:0]   s_ready;
`ifdef MMIO_MAPPER_ERRLOG_EN
    logic              irq, irq_clr;
    logic [AW-1:0]     elog_a;
    logic              elog_kind;
`endif

    int checks   = 0;
    int failures = 0;

    // Slave latency model: a strobe loads busy with lat; ready is low while busy != 0.
    int lat  [NSLV];
    int busy [NSLV];

    assign s_spo = {32'h1234_5678, 32'h2222_2222, 32'h1111_1111, 32'hB007_0000};

    always_comb begin
        for (int i = 0; i < NSLV; i++) s_ready[i] = (busy[i] == 0);
    end

    always @(posedge clk) begin
        for (int i = 0; i < NSLV; i++) begin
            if (rst) busy[i] <= 0;
            else if (s_we[i] || s_rd[i]) busy[i] <= lat[i];
            else if (busy[i] != 0) busy[i] <= busy[i] - 1;
        end
    end

    mmio_mapper #(
        .NSLV     (NSLV),
        .AW       (AW),
        .DW       (DW),
        .BASE     ({32'h9300_0000, 32'h2000_0000, 32'h2000_0000, 32'hF000_0000}),
        .MASK     ({32'hFF00_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000}),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a_i),
        .d         (d_i),
        .we        (we_i),
        .rd        (rd_i),
        .spo       (spo),
        .ready     (ready),
        .err       (err),
`ifdef MMIO_MAPPER_ERRLOG_EN
        .irq       (irq),
        .irq_clr   (irq_clr),
        .elog_a    (elog_a),
        .elog_kind (elog_kind),
`endif
        .s_a       (s_a),
        .s_d       (s_d),
        .s_we      (s_we),
        .s_rd      (s_rd),
        .s_spo     (s_spo),
        .s_ready   (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        rd;
        int          lat2;
        int          slv;
        logic [31:0] spo;
        logic        err;
        logic        kind;
        int          cyc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        int          n;
        bit          done;
        int          we_cnt [NSLV];
        int          rd_cnt [NSLV];
        logic [31:0] seen_a, seen_d;
        int          sidx;
        sidx   = (v.slv < 0) ? 0 : v.slv;
        seen_a = '0;
        seen_d = '0;
        for (int i = 0; i < NSLV; i++) begin
            we_cnt[i] = 0;
            rd_cnt[i] = 0;
        end
        lat[2] = v.lat2;
        @(negedge clk);
        a_i = v.a; d_i = v.d; we_i = v.we; rd_i = v.rd;
        #1;
        chk("ready_low_on_req", {63'd0, ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        we_i = 1'b0; rd_i = 1'b0;
        a_i = 32'hFFFF_FFFF; d_i = 32'h0;
        n = 1;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            for (int i = 0; i < NSLV; i++) begin
                we_cnt[i] += int'(s_we[i]);
                rd_cnt[i] += int'(s_rd[i]);
            end
            if (s_we != '0 || s_rd != '0) begin
                seen_a = s_a[sidx*AW +: AW];
                seen_d = s_d[sidx*DW +: DW];
            end
            if (ready) done = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("completion_bound", {63'd0, done}, 64'd1);
        chk("ready_latency", 64'(n), 64'(v.cyc));
        chk("spo", {32'd0, spo}, {32'd0, v.spo});
        chk("err", {63'd0, err}, {63'd0, v.err});
        for (int i = 0; i < NSLV; i++) begin
            chk("we_strobes", 64'(we_cnt[i]), (i == v.slv && v.we) ? 64'd1 : 64'd0);
            chk("rd_strobes", 64'(rd_cnt[i]), (i == v.slv && !v.we && v.rd) ? 64'd1 : 64'd0);
        end
        if (v.slv >= 0) begin
            chk("s_a_latched", {32'd0, seen_a}, {32'd0, v.a});
            if (v.we) chk("s_d_latched", {32'd0, seen_d}, {32'd0, v.d});
        end
        $display("txn %0d a=%h we=%b rd=%b spo=%h err=%b cycles=%0d", idx, v.a, v.we, v.rd, spo, err, n);
        repeat (2) @(negedge clk);
        chk("spo_hold", {32'd0, spo}, {32'd0, v.spo});
        chk("err_hold", {63'd0, err}, {63'd0, v.err});
`ifdef MMIO_MAPPER_ERRLOG_EN
        if (v.err) begin
            chk("irq_set", {63'd0, irq}, 64'd1);
            chk("elog_a", {32'd0, elog_a}, {32'd0, v.a});
            chk("elog_kind", {63'd0, elog_kind}, {63'd0, v.kind});
            irq_clr = 1'b1;
            @(negedge clk);
            irq_clr = 1'b0;
            chk("irq_cleared", {63'd0, irq}, 64'd0);
        end
`endif
    endtask

    initial begin
        vecs[0] = '{32'h9300_0004, 32'h0000_0000, 1'b0, 1'b1, 0,    3, 32'h1234_5678, 1'b0, 1'b0, 5};
        vecs[1] = '{32'h2100_0000, 32'hA5A5_A5A5, 1'b1, 1'b0, 7,    2, 32'h2222_2222, 1'b0, 1'b0, 11};
        vecs[2] = '{32'h5000_0000, 32'h0000_0000, 1'b0, 1'b1, 0,   -1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2};
        vecs[3] = '{32'h2100_0004, 32'h0000_0000, 1'b0, 1'b1, 1000, 2, 32'hDEAD_BEEF, 1'b1, 1'b1, 12};
        vecs[4] = '{32'hF000_0100, 32'h0000_0000, 1'b0, 1'b1, 0,    0, 32'hB007_0000, 1'b0, 1'b0, 5};
        vecs[5] = '{32'h2000_0010, 32'h0000_0000, 1'b0, 1'b1, 0,    1, 32'h1111_1111, 1'b0, 1'b0, 5};
        vecs[6] = '{32'h9300_0008, 32'h5A5A_5A5A, 1'b1, 1'b1, 0,    3, 32'h1234_5678, 1'b0, 1'b0, 5};
        vecs[7] = '{32'h2000_0000, 32'h0F0F_0F0F, 1'b1, 1'b0, 0,    1, 32'h1111_1111, 1'b0, 1'b0, 5};
        vecs[8] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 0,   -1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2};

        for (int i = 0; i < NSLV; i++) lat[i] = 0;
        rst = 1'b1; a_i = '0; d_i = '0; we_i = 1'b0; rd_i = 1'b0;
`ifdef MMIO_MAPPER_ERRLOG_EN
        irq_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {63'd0, ready}, 64'd1);
        chk("reset_spo", {32'd0, spo}, 64'd0);
        chk("reset_err", {63'd0, err}, 64'd0);
        chk("reset_strobes", {56'd0, s_we, s_rd}, 64'd0);
`ifdef MMIO_MAPPER_ERRLOG_EN
        chk("reset_irq", {63'd0, irq}, 64'd0);
`endif

        for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

        // Abort a transaction in WAIT with reset.
        lat[2] = 1000;
        @(negedge clk);
        a_i = 32'h2100_0000; rd_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_not_ready", {63'd0, ready}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", {63'd0, ready}, 64'd1);
        chk("abort_strobes", {56'd0, s_we, s_rd}, 64'd0);
        chk("abort_spo", {32'd0, spo}, 64'd0);
        chk("abort_err", {63'd0, err}, 64'd0);
        rst = 1'b0;
        $display("txn abort a=21000000 reset in WAIT ready=%b spo=%h err=%b", ready, spo, err);

        run_txn(9, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
